gbd_mbc_ctrl: RTL and testbench

//  Parametrised cartridge memory-bank controller. Captures cart register writes (RAM enable,
//  ROM bank, RAM/register bank), steers cart RAM strobes for A000-BFFF, and arbitrates the

---
 rtl/gbd_mbc_pkg.sv | 21 ++
 rtl/gbd_mbc_if.sv | 49 ++++
 rtl/gbd_sync_edge.sv | 28 ++
 rtl/gbd_mbc_ctrl.sv | 152 +++++++++++++++
 tb/tb_gbd_mbc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbd_mbc_pkg.sv
// Shared constants for the cartridge bank controller.
// Region decode, arbiter state codes and register reset values.
package gbd_mbc_pkg;

  localparam logic [3:0] REG_RAMEN   = 4'h0;
  localparam logic [3:0] REG_ROMLO   = 4'h2;
  localparam logic [3:0] REG_ROMHI   = 4'h3;
  localparam logic [3:0] REG_RAMBANK = 4'h4;
  localparam logic [2:0] REGION_SRAM = 3'b101;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_WAIT = 2'd1;
  localparam arb_state_t ARB_HOST = 2'd2;
  localparam arb_state_t ARB_REL  = 2'd3;

  localparam int ROM_BANK_RST = 1;
  localparam int RAM_BANK_RST = 0;

endpackage

// File: rtl/gbd_mbc_if.sv
// Cart edge, cart SRAM, host handshake and status bundle.
// slave = controller side, master = cart/host/SRAM side.
interface gbd_mbc_if #(
  parameter int RAM_BANK_BITS = 4,
  parameter int ROM_BANK_BITS = 9
);
  logic [15:0]              cart_a;
  logic [7:0]               cart_d_in;
  logic [7:0]               cart_d_out;
  logic                     cart_d_oe;
  logic                     cart_nwr;
  logic                     cart_nrd;
  logic                     cart_ncs;
  logic [7:0]               ram_rdata;
  logic [RAM_BANK_BITS-1:0] ram_a_hi;
  logic                     ram_ncs;
  logic                     ram_nwe;
  logic                     ram_noe;
  logic                     ram_host_sel;
  logic                     host_req;
  logic                     host_gnt;
  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [RAM_BANK_BITS:0]   ram_bank;
  logic                     ram_wren;
  logic                     reg_space;
  logic [15:0]              ram_wr_count;

  modport slave (
    input  cart_a, cart_d_in, cart_nwr,
    input  cart_nrd, cart_ncs, ram_rdata,
    input  host_req,
    output cart_d_out, cart_d_oe, ram_a_hi,
    output ram_ncs, ram_nwe, ram_noe,
    output ram_host_sel, host_gnt, rom_bank,
    output ram_bank, ram_wren, reg_space,
    output ram_wr_count
  );

  modport master (
    output cart_a, cart_d_in, cart_nwr,
    output cart_nrd, cart_ncs, ram_rdata,
    output host_req,
    input  cart_d_out, cart_d_oe, ram_a_hi,
    input  ram_ncs, ram_nwe, ram_noe,
    input  ram_host_sel, host_gnt, rom_bank,
    input  ram_bank, ram_wren, reg_space,
    input  ram_wr_count
  );
endinterface

// File: rtl/gbd_sync_edge.sv
// Multi-flop synchroniser for an active-low cart strobe.
// Gives the synced level and a one-cycle falling-edge pulse.
module gbd_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clock,
  input  logic sys_resetn,
  input  logic async_in,
  output logic lvl,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic              prev;

  // shift the pin in; strobes idle high so reset to 1
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sr   <= '1;
      prev <= 1'b1;
    end else begin
      sr   <= {sr[STAGES-2:0], async_in};
      prev <= sr[STAGES-1];
    end
  end

  assign lvl  = sr[STAGES-1];
  assign fall = prev & ~lvl;
endmodule

// File: rtl/gbd_mbc_ctrl.sv
// Cartridge bank controller: bank registers, SRAM steering, host arbiter.
// Optional GBD_MBC_WRITE_COUNT_EN adds a saturating SRAM write counter.
module gbd_mbc_ctrl
  import gbd_mbc_pkg::*;
#(
  parameter int RAM_BANK_BITS = 4,
  parameter int ROM_BANK_BITS = 9,
  parameter int SYNC_STAGES   = 2,
  parameter int IDLE_CYCLES   = 4
) (
  input logic      sys_clock,
  input logic      sys_resetn,
  gbd_mbc_if.slave bus
);
  localparam int MSB = RAM_BANK_BITS;
  localparam int CW  = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);
  localparam logic [ROM_BANK_BITS-1:0] ROM_RST =
    ROM_BANK_RST[ROM_BANK_BITS-1:0];
  localparam logic [RAM_BANK_BITS:0] BANK_RST =
    RAM_BANK_RST[RAM_BANK_BITS:0];

  logic nwr_fall, nwr_lvl;
  logic ncs_fall, ncs_lvl;

  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [RAM_BANK_BITS:0]   ram_bank;
  logic                     ram_wren;

  arb_state_t    state;
  logic [CW-1:0] idle_cnt;
  logic          gnt;

  logic [3:0] hi;
  logic       sram_rgn;
  logic       host;
  logic       acc;
  logic       unused_ok;

  gbd_sync_edge #(.STAGES(SYNC_STAGES)) u_nwr_sync (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .async_in   (bus.cart_nwr),
    .lvl        (nwr_lvl),
    .fall       (nwr_fall)
  );

  gbd_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .async_in   (bus.cart_ncs),
    .lvl        (ncs_lvl),
    .fall       (ncs_fall)
  );

  assign hi       = bus.cart_a[15:12];
  assign sram_rgn = bus.cart_a[15:13] == REGION_SRAM;
  assign host     = state == ARB_HOST;
  assign acc      = sram_rgn && !ram_bank[MSB] && !host;

  // cart register writes, taken on each synced nWR fall
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rom_bank <= ROM_RST;
      ram_bank <= BANK_RST;
      ram_wren <= 1'b0;
    end else if (nwr_fall) begin
      unique case (1'b1)
        (hi[3:1] == REG_RAMEN[3:1]):
          ram_wren <= bus.cart_d_in[3:0] == 4'hA;
        (hi == REG_ROMLO):
          rom_bank[7:0] <= bus.cart_d_in;
        (hi == REG_ROMHI):
          if (ROM_BANK_BITS == 9)
            rom_bank[ROM_BANK_BITS-1] <= bus.cart_d_in[0];
        (hi[3:1] == REG_RAMBANK[3:1]):
          ram_bank <= bus.cart_d_in[RAM_BANK_BITS:0];
        default: ;
      endcase
    end
  end

  // host arbitration: grant only after a quiet cart bus
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state    <= ARB_IDLE;
      idle_cnt <= '0;
      gnt      <= 1'b0;
    end else begin
      gnt <= host && bus.host_req;
      unique case (state)
        ARB_IDLE:
          if (bus.host_req) begin
            state    <= ARB_WAIT;
            idle_cnt <= '0;
          end
        ARB_WAIT:
          if (!bus.host_req)
            state <= ARB_IDLE;
          else if (idle_cnt == IDLE_MAX)
            state <= ARB_HOST;
          else if (ncs_lvl)
            idle_cnt <= idle_cnt + 1'b1;
          else
            idle_cnt <= '0;
        ARB_HOST:
          if (!bus.host_req)
            state <= ARB_REL;
        ARB_REL:
          state <= ARB_IDLE;
        default:
          state <= ARB_IDLE;
      endcase
    end
  end

`ifdef GBD_MBC_WRITE_COUNT_EN
  logic [15:0] wr_count;

  // count accepted cart SRAM writes, saturating
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn)
      wr_count <= '0;
    else if (nwr_fall && acc && ram_wren &&
             wr_count != 16'hFFFF)
      wr_count <= wr_count + 16'd1;
  end

  assign bus.ram_wr_count = wr_count;
`else
  assign bus.ram_wr_count = 16'h0000;
`endif

  assign bus.ram_ncs = acc ? bus.cart_ncs : 1'b1;
  assign bus.ram_nwe = (acc && ram_wren) ?
                       bus.cart_nwr : 1'b1;
  assign bus.ram_noe = acc ? bus.cart_nrd : 1'b1;
  assign bus.ram_a_hi = ram_bank[RAM_BANK_BITS-1:0];

  assign bus.cart_d_oe = sram_rgn && !bus.cart_ncs &&
                         !bus.cart_nrd && !ram_bank[MSB];
  assign bus.cart_d_out = host ? 8'hFF : bus.ram_rdata;
  assign bus.reg_space  = sram_rgn && ram_bank[MSB];

  assign bus.host_gnt     = gnt;
  assign bus.ram_host_sel = gnt;
  assign bus.rom_bank     = rom_bank;
  assign bus.ram_bank     = ram_bank;
  assign bus.ram_wren     = ram_wren;

  assign unused_ok = ^{bus.cart_a[11:0], nwr_lvl, ncs_fall};
endmodule

// File: tb/tb_gbd_mbc_ctrl.sv
// Self-checking bench for gbd_mbc_ctrl: vector table, random
// register/SRAM-path traffic vs a spec model, arbitration sequences.
module tb_gbd_mbc_ctrl;
  localparam int RB = 4;
  localparam int ROMB = 9;
  localparam int SS = 2;
  localparam int IC = 4;

  logic sys_clock = 1'b0;
  logic sys_resetn;

  gbd_mbc_if #(
    .RAM_BANK_BITS (RB),
    .ROM_BANK_BITS (ROMB)
  ) bus ();

  gbd_mbc_ctrl #(
    .RAM_BANK_BITS (RB),
    .ROM_BANK_BITS (ROMB),
    .SYNC_STAGES   (SS),
    .IDLE_CYCLES   (IC)
  ) dut (
    .sys_clock  (sys_clock),
    .sys_resetn (sys_resetn),
    .bus        (bus)
  );

  always #5 sys_clock = ~sys_clock;

  int checks = 0;
  int errors = 0;

  // spec-level model of the controller registers
  logic       m_wren;
  logic [8:0] m_rom;
  logic [4:0] m_bank;
  int         m_cnt;
  logic       host_on;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        wren;
    logic [8:0]  rom;
    logic [4:0]  bank;
    logic        probe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wren  = 1'b0;
    m_rom   = 9'h001;
    m_bank  = 5'h00;
    m_cnt   = 0;
    host_on = 1'b0;
  endtask

  task automatic model_wr(input logic [15:0] a,
                          input logic [7:0] d);
    int n;
    logic sram;
    n = int'(a[15:12]);
    sram = (a >= 16'hA000) && (a <= 16'hBFFF);
`ifdef GBD_MBC_WRITE_COUNT_EN
    if (sram && !m_bank[4] && !host_on && m_wren)
      m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
`endif
    if (n <= 1)
      m_wren = (d[3:0] == 4'hA);
    else if (n == 2)
      m_rom[7:0] = d;
    else if (n == 3)
      m_rom[8] = d[0];
    else if (n == 4 || n == 5)
      m_bank = d[4:0];
  endtask

  task automatic cart_wr(input logic [15:0] a,
                         input logic [7:0] d);
    logic sram;
    logic acc;
    sram = (a >= 16'hA000) && (a <= 16'hBFFF);
    @(negedge sys_clock);
    bus.cart_a    = a;
    bus.cart_d_in = d;
    bus.cart_ncs  = sram ? 1'b0 : 1'b1;
    @(negedge sys_clock);
    bus.cart_nwr = 1'b0;
    if (sram) begin
      #1;
      acc = !m_bank[4] && !host_on;
      chk("ram_nwe_wr", 32'(bus.ram_nwe),
          32'((acc && m_wren) ? 1'b0 : 1'b1));
    end
    repeat (SS + 2) @(negedge sys_clock);
    bus.cart_nwr = 1'b1;
    bus.cart_ncs = 1'b1;
    repeat (2) @(negedge sys_clock);
    model_wr(a, d);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_rom"}, 32'(bus.rom_bank), 32'(m_rom));
    chk({tag, "_bank"}, 32'(bus.ram_bank), 32'(m_bank));
    chk({tag, "_wren"}, 32'(bus.ram_wren), 32'(m_wren));
    chk({tag, "_cnt"}, 32'(bus.ram_wr_count), 32'(m_cnt));
  endtask

  task automatic comb_chk(input string nm,
                          input logic [15:0] a,
                          input logic ncs,
                          input logic nrd,
                          input logic [7:0] rd);
    logic sram;
    logic acc;
    logic [13:0] exp;
    sram = (a >= 16'hA000) && (a <= 16'hBFFF);
    acc  = sram && !m_bank[4] && !host_on;
    bus.cart_a    = a;
    bus.cart_ncs  = ncs;
    bus.cart_nrd  = nrd;
    bus.ram_rdata = rd;
    #1;
    exp = {acc ? ncs : 1'b1,
           1'b1,
           acc ? nrd : 1'b1,
           sram && !ncs && !nrd && !m_bank[4],
           sram && m_bank[4],
           host_on ? 8'hFF : rd,
           m_bank[0]};
    chk(nm, 32'({bus.ram_ncs, bus.ram_nwe,
                 bus.ram_noe, bus.cart_d_oe,
                 bus.reg_space, bus.cart_d_out,
                 bus.ram_a_hi[0]}), 32'(exp));
    chk({nm, "_ahi"}, 32'(bus.ram_a_hi),
        32'(m_bank[3:0]));
  endtask

  task automatic wait_gnt(input string nm);
    int n = 0;
    while (!bus.host_gnt && n < 30) begin
      @(negedge sys_clock);
      n++;
    end
    chk(nm, 32'(bus.host_gnt), 32'd1);
    chk({nm, "_sel"}, 32'(bus.ram_host_sel), 32'd1);
  endtask

  initial begin
    logic saw;
    logic [15:0] ra;

    vecs[0]  = '{16'h0000, 8'h0A, 1, 9'h001, 5'h00, 0};
    vecs[1]  = '{16'h0000, 8'h05, 0, 9'h001, 5'h00, 0};
    vecs[2]  = '{16'h1000, 8'h1A, 1, 9'h001, 5'h00, 0};
    vecs[3]  = '{16'h2000, 8'h3C, 1, 9'h03C, 5'h00, 0};
    vecs[4]  = '{16'h3000, 8'h01, 1, 9'h13C, 5'h00, 0};
    vecs[5]  = '{16'h2000, 8'h00, 1, 9'h100, 5'h00, 0};
    vecs[6]  = '{16'h4000, 8'h13, 1, 9'h100, 5'h13, 1};
    vecs[7]  = '{16'h6000, 8'h55, 1, 9'h100, 5'h13, 0};
    vecs[8]  = '{16'h4000, 8'h03, 1, 9'h100, 5'h03, 1};
    vecs[9]  = '{16'h3000, 8'h00, 1, 9'h000, 5'h03, 0};
    vecs[10] = '{16'h2000, 8'h01, 1, 9'h001, 5'h03, 0};

    bus.cart_a    = 16'h0000;
    bus.cart_d_in = 8'h00;
    bus.cart_nwr  = 1'b1;
    bus.cart_nrd  = 1'b1;
    bus.cart_ncs  = 1'b1;
    bus.ram_rdata = 8'h00;
    bus.host_req  = 1'b0;
    sys_resetn    = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clock);
    check_regs("rst");
    chk("rst_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_sel", 32'(bus.ram_host_sel), 32'd0);
    sys_resetn = 1'b1;
    repeat (2) @(negedge sys_clock);

    for (int i = 0; i < 11; i++) begin
      cart_wr(vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_wren", i),
          32'(bus.ram_wren), 32'(vecs[i].wren));
      chk($sformatf("vec%0d_rom", i),
          32'(bus.rom_bank), 32'(vecs[i].rom));
      chk($sformatf("vec%0d_bank", i),
          32'(bus.ram_bank), 32'(vecs[i].bank));
      if (vecs[i].probe)
        comb_chk($sformatf("vec%0d_path", i),
                 16'hA000, 1'b0, 1'b1, 8'h5A);
      bus.cart_ncs = 1'b1;
      bus.cart_nrd = 1'b1;
    end

    cart_wr(16'h0000, 8'h0A);
    cart_wr(16'h4000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cart_wr(16'hA000, 8'(i));
      check_regs("cnt_en");
    end
    cart_wr(16'h0000, 8'h00);
    cart_wr(16'hA000, 8'h11);
    check_regs("cnt_dis");

    for (int i = 0; i < 120; i++) begin
      ra = {4'($urandom_range(0, 15)), 12'($urandom)};
      cart_wr(ra, 8'($urandom));
      check_regs("rnd");
      comb_chk("rnd_path", 16'($urandom),
               1'($urandom), 1'($urandom),
               8'($urandom));
      bus.cart_ncs = 1'b1;
      bus.cart_nrd = 1'b1;
    end

    @(negedge sys_clock);
    bus.cart_a   = 16'h0000;
    bus.cart_ncs = 1'b0;
    bus.host_req = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 36; i++) begin
      bus.cart_ncs = ((i / 3) % 2) != 0;
      @(negedge sys_clock);
      if (bus.host_gnt) saw = 1'b1;
    end
    bus.cart_ncs = 1'b0;
    repeat (4) begin
      @(negedge sys_clock);
      if (bus.host_gnt) saw = 1'b1;
    end
    chk("no_gnt_busy", 32'(saw), 32'd0);
    bus.cart_ncs = 1'b1;
    repeat (SS + IC - 1) begin
      @(negedge sys_clock);
      if (bus.host_gnt) saw = 1'b1;
    end
    chk("gnt_early", 32'(saw), 32'd0);
    wait_gnt("gnt_rise");
    host_on = 1'b1;

    cart_wr(16'h0000, 8'h0A);
    cart_wr(16'h4000, 8'h00);
    cart_wr(16'h2000, 8'h07);
    check_regs("host_reg");
    cart_wr(16'hA000, 8'h77);
    check_regs("host_drop");
    comb_chk("host_rd", 16'hA000, 1'b0, 1'b0, 8'h3C);
    chk("host_hold", 32'(bus.host_gnt), 32'd1);
    bus.cart_ncs = 1'b1;
    bus.cart_nrd = 1'b1;

    @(negedge sys_clock);
    bus.host_req = 1'b0;
    @(negedge sys_clock);
    chk("rel_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rel_sel", 32'(bus.ram_host_sel), 32'd0);
    host_on = 1'b0;
    comb_chk("rel_path", 16'hA000, 1'b0, 1'b1, 8'h00);
    bus.cart_ncs = 1'b1;
    bus.host_req = 1'b1;
    @(negedge sys_clock);
    wait_gnt("gnt_again");
    host_on = 1'b1;

    #2 sys_resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", 32'(bus.host_gnt), 32'd0);
    chk("arst_sel", 32'(bus.ram_host_sel), 32'd0);
    check_regs("arst");
    bus.host_req = 1'b0;
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    repeat (3) @(negedge sys_clock);
    chk("post_rst_gnt", 32'(bus.host_gnt), 32'd0);
    check_regs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
